// File: rtl/pool_stream_packer.sv
// Stream packer: gathers the kept words of each input beat into a word buffer
// and emits dense M_WORDS-wide output beats, flushing the remainder with last.
module pool_stream_packer #(
  parameter int UNITS      = 2,
  parameter int GROUPS     = 2,
  parameter int WORD_WIDTH = 8,
  parameter int M_WORDS    = 4,
  localparam int N_IN      = GROUPS * UNITS * 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          clken,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_IN*WORD_WIDTH-1:0]    s_data_flat_cgu,
  input  logic [N_IN-1:0]               s_keep_flat_cgu,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [M_WORDS*WORD_WIDTH-1:0] m_data,
  output logic [M_WORDS-1:0]            m_keep,
  output logic                          m_last
);

  localparam int BUF_DEPTH = N_IN + M_WORDS;
  localparam int CW        = $clog2(BUF_DEPTH + 1);

  typedef enum logic {FILL, FLUSH} state_t;

  logic [BUF_DEPTH-1:0][WORD_WIDTH-1:0] mem_q, mem_d;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  int            cnt, out_cnt, pop_n, base, pos;
  logic          s_fire, m_fire;

  assign cnt     = int'(count_q);
  // Ready depends only on registered state, so no path from m_ready/s_valid.
  assign s_ready = (state_q == FILL) && (cnt <= M_WORDS);
  assign s_fire  = clken && s_valid && s_ready;
  assign m_fire  = clken && m_valid && m_ready;

  // Output beat view of the buffer head; FILL keeps one word back for last.
  always_comb begin
    m_keep  = '0;
    m_data  = '0;
    out_cnt = (state_q == FLUSH && cnt < M_WORDS) ? cnt : M_WORDS;
    m_valid = (state_q == FILL) ? (cnt > M_WORDS) : (cnt > 0);
    m_last  = (state_q == FLUSH) && (cnt > 0) && (cnt <= M_WORDS);
    for (int j = 0; j < M_WORDS; j++) begin
      m_keep[j] = m_valid && (j < out_cnt);
      m_data[j*WORD_WIDTH +: WORD_WIDTH] = m_keep[j] ? mem_q[j] : '0;
    end
  end

  // Buffer update: drop popped head words, then compact kept input words onto the tail.
  always_comb begin
    mem_d = '0;
    pop_n = m_fire ? out_cnt : 0;
    base  = cnt - pop_n;
    pos   = 0;
    for (int j = 0; j < BUF_DEPTH; j++)
      if (j + pop_n < BUF_DEPTH) mem_d[j] = mem_q[j + pop_n];
    if (s_fire) begin
      for (int i = 0; i < N_IN; i++) begin
        if (s_keep_flat_cgu[i]) begin
          if (base + pos < BUF_DEPTH)
            mem_d[base + pos] = s_data_flat_cgu[i*WORD_WIDTH +: WORD_WIDTH];
          pos = pos + 1;
        end
      end
    end
    count_d = CW'(base + pos);
  end

  // FILL/FLUSH sequencing; an empty flush returns to FILL after one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (s_fire && s_last) state_d = FLUSH;
      FLUSH:   if (cnt == 0 || (m_fire && m_last)) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // State registers; everything holds while clken is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q   <= '0;
      count_q <= '0;
      state_q <= FILL;
    end else if (clken) begin
      mem_q   <= mem_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule
